sram_bank_dp: RTL and testbench
===============================

Name: sram_bank_dp

Overview:
- Synthesizable, parametrised dual-port byte-lane SRAM bank; replaces the single-port, read-only instruction memory model in the core bench.
- Port I: read-only instruction fetch. Port D: load/store data access with per-byte write enables.
- Adds configurable read latency with valid strobes, misalignment and out-of-range detection, and defined read-during-write behaviour.
- Sits between core (ins_*/dat_* buses) and the bench or SoC top.

Parameters:
- DW, 32, data word width in bits; multiple of 8; NB = DW/8 byte lanes.
- AW, 16, byte-address width of both ports.
- DEPTH, 16384, number of words; must be ≤ 2^(AW-log2(NB)).
- RD_LAT, 1, read latency in cycles (1..4) for both ports.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- ins_e  in  1  instruction read enable.
- ins_a  in  AW  instruction byte address.
- ins  out  DW  instruction read data.
- ins_v  out  1  ins valid strobe.
- dat_re  in  1  data read enable.
- dat_we  in  NB  per-byte write enables.
- dat_a  in  AW  data byte address.
- dat_wd  in  DW  write data, byte k on [8k+7:8k].
- dat_rd  out  DW  data read data.
- dat_v  out  1  dat_rd valid strobe.
- err  out  1  one-cycle error pulse, aligned with the offending access's valid slot.

Behaviour:
- Reset: ins, dat_rd = 0; ins_v, dat_v, err = 0; latency pipelines cleared. Array contents are not reset.
- Word index = a[AW-1:log2(NB)]. Byte lanes are stored in NB separate 8-bit arrays.
- Read, either port: accepted on an edge with e=1. Data and valid appear exactly RD_LAT cycles later.
  - ins/dat_rd hold their last value while the corresponding valid is 0.
  - Back-to-back reads are fully pipelined: throughput 1 per cycle.
- Write: on an edge with any dat_we bit set, lanes with we[k]=1 are updated; other lanes are untouched. No valid is produced for a write.
- dat_re and dat_we both set: write is performed; the read returns pre-write data.
- Misaligned: dat_a or ins_a low log2(NB) bits ≠ 0.
  - Access suppressed, no write.
  - Returned data = 0, valid still asserted, err=1 in that valid slot.
- Out of range: word index ≥ DEPTH. Same handling as misaligned.
- For a write, err is pulsed RD_LAT cycles later for timing consistency.
- Port I reads the same word Port D writes in the same cycle:
  - Default: returns old data.
  - See the optional feature below.
- Port D read-after-write on consecutive cycles returns the new data; no hazard.
- Reset asserted mid-operation: all in-flight reads are dropped; no valid is emitted after rstn rises for requests issued before reset.
- err = OR of both ports' error conditions in the same slot.

Optional Feature:
- Macro SRAM_BANK_BYPASS_EN.
- Defined: a same-cycle Port I read of a word being written by Port D returns the merged word — new bytes where dat_we[k]=1, old bytes elsewhere.
- Undefined: Port I returns the pre-write word.
- Port D is unaffected either way.

Test Plan:
- Reset/latency: RD_LAT=2, preload word 0x10 with 0xDEADBEEF; ins_e=1, ins_a=0x0040 at cycle 0 -> ins_v=1, ins=0xDEADBEEF at cycle 2; ins_v=0 at cycles 0, 1, 3.
- Byte write: word 0x5 = 0x11223344; dat_we=4'b0101, dat_a=0x0014, dat_wd=0xAABBCCDD, then dat_re next cycle -> dat_rd=0x11BB33DD.
- Pipelined reads: ins_e held 4 cycles at addrs 0x0, 0x4, 0x8, 0xC with RD_LAT=1 -> 4 consecutive ins_v pulses carrying words 0..3 in order.
- Errors: dat_re at dat_a=0x0002 -> dat_v=1, dat_rd=0, err=1. ins_a=0xFFFC with DEPTH=1024 -> ins=0, err=1. Array unchanged.
- Collision: word 7 = 0x0; same cycle ins_a=0x1C and dat_we=4'hF, dat_wd=0xCAFEF00D -> ins=0x00000000 without macro, 0xCAFEF00D with SRAM_BANK_BYPASS_EN.
- Reset mid-flight: RD_LAT=3, issue read, assert rstn=0 one cycle later for 1 cycle -> ins_v never asserts for that request; ins=0.

Source files
------------

// File: rtl/sram_bank_dp.sv
// sram_bank_dp: dual-port byte-lane SRAM bank (port I fetch, port D load/store) with RD_LAT-deep read pipelines.
// Define SRAM_BANK_BYPASS_EN to forward same-cycle port D write bytes into a colliding port I read.
module sram_bank_dp #(
  parameter int DW     = 32,
  parameter int AW     = 16,
  parameter int DEPTH  = 16384,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ins_e,
  input  logic [AW-1:0]    ins_a,
  output logic [DW-1:0]    ins,
  output logic             ins_v,
  input  logic             dat_re,
  input  logic [DW/8-1:0]  dat_we,
  input  logic [AW-1:0]    dat_a,
  input  logic [DW-1:0]    dat_wd,
  output logic [DW-1:0]    dat_rd,
  output logic             dat_v,
  output logic             err
);
  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] AMASK = AW'(NB - 1);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
  logic [AW-1:0] iwd, dwd;
  logic [IW-1:0] iwi, dwi;
  logic          i_ok, d_ok, byp, err_in;
  logic [DW-1:0] iraw, draw;
  logic [RD_LAT-1:0] iv_p, dv_p, er_p;
  logic [DW-1:0] id_p [RD_LAT];
  logic [DW-1:0] dd_p [RD_LAT];
  assign iwd = ins_a >> LB;
  assign dwd = dat_a >> LB;
  assign i_ok = ((ins_a & AMASK) == '0) && ({1'b0, iwd} < DEPTH_L);
  assign d_ok = ((dat_a & AMASK) == '0) && ({1'b0, dwd} < DEPTH_L);
  assign iwi = IW'(iwd);
  assign dwi = IW'(dwd);
  assign err_in = (ins_e & ~i_ok) | ((dat_re | (|dat_we)) & ~d_ok);
`ifdef SRAM_BANK_BYPASS_EN
  assign byp = d_ok && i_ok && (dwi == iwi);
`else
  assign byp = 1'b0;
`endif
  // one 8-bit array per lane; a bad address must never write, since the truncated index aliases
  for (genvar k = 0; k < NB; k++) begin : g_lane
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk)
      if (d_ok && dat_we[k]) mem[dwi] <= dat_wd[8*k +: 8];
    assign iraw[8*k +: 8] = (byp && dat_we[k]) ? dat_wd[8*k +: 8] : mem[iwi];
    assign draw[8*k +: 8] = mem[dwi];
  end
  // data stages only load behind a valid so outputs hold between strobes
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      iv_p <= '0;
      dv_p <= '0;
      er_p <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        id_p[k] <= '0;
        dd_p[k] <= '0;
      end
    end else begin
      iv_p[0] <= ins_e;
      dv_p[0] <= dat_re;
      er_p[0] <= err_in;
      if (ins_e) id_p[0] <= i_ok ? iraw : '0;
      if (dat_re) dd_p[0] <= d_ok ? draw : '0;
      for (int k = 1; k < RD_LAT; k++) begin
        iv_p[k] <= iv_p[k-1];
        dv_p[k] <= dv_p[k-1];
        er_p[k] <= er_p[k-1];
        if (iv_p[k-1]) id_p[k] <= id_p[k-1];
        if (dv_p[k-1]) dd_p[k] <= dd_p[k-1];
      end
    end
  assign ins    = id_p[RD_LAT-1];
  assign ins_v  = iv_p[RD_LAT-1];
  assign dat_rd = dd_p[RD_LAT-1];
  assign dat_v  = dv_p[RD_LAT-1];
  assign err    = er_p[RD_LAT-1];
endmodule

// File: tb/tb_sram_bank_dp.sv
// tb_sram_bank_dp: directed checks of sram_bank_dp with DEPTH=1024, RD_LAT=2.
module tb_sram_bank_dp;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ins_e = 1'b0;
  logic [15:0] ins_a = '0;
  logic [31:0] ins;
  logic        ins_v;
  logic        dat_re = 1'b0;
  logic [3:0]  dat_we = '0;
  logic [15:0] dat_a = '0;
  logic [31:0] dat_wd = '0;
  logic [31:0] dat_rd;
  logic        dat_v;
  logic        err;
  int errors = 0;
  int checks = 0;

  sram_bank_dp #(.DW(32), .AW(16), .DEPTH(1024), .RD_LAT(2)) dut (
    .clk(clk), .rstn(rstn), .ins_e(ins_e), .ins_a(ins_a), .ins(ins), .ins_v(ins_v),
    .dat_re(dat_re), .dat_we(dat_we), .dat_a(dat_a), .dat_wd(dat_wd),
    .dat_rd(dat_rd), .dat_v(dat_v), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [3:0] we, input logic [31:0] d);
    dat_a = a;
    dat_we = we;
    dat_wd = d;
    tick();
    dat_we = '0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    tick();
    tick();
    checks++; if (ins !== 32'h0) begin errors++; $display("FAIL reset_ins: got %h expected %h", ins, 32'h0); end
    checks++; if (ins_v !== 1'b0) begin errors++; $display("FAIL reset_ins_v: got %b expected 0", ins_v); end
    checks++; if (dat_rd !== 32'h0) begin errors++; $display("FAIL reset_dat_rd: got %h expected %h", dat_rd, 32'h0); end
    checks++; if (dat_v !== 1'b0) begin errors++; $display("FAIL reset_dat_v: got %b expected 0", dat_v); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_latency;
    wr(16'h0040, 4'hF, 32'hDEADBEEF);
    ins_e = 1'b1;
    ins_a = 16'h0040;
    checks++; if (ins_v !== 1'b0) begin errors++; $display("FAIL lat_c0_v: got %b expected 0", ins_v); end
    tick();
    ins_e = 1'b0;
    checks++; if (ins_v !== 1'b0) begin errors++; $display("FAIL lat_c1_v: got %b expected 0", ins_v); end
    tick();
    checks++; if (ins_v !== 1'b1) begin errors++; $display("FAIL lat_c2_v: got %b expected 1", ins_v); end
    checks++; if (ins !== 32'hDEADBEEF) begin errors++; $display("FAIL lat_c2_data: got %h expected %h", ins, 32'hDEADBEEF); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL lat_c2_err: got %b expected 0", err); end
    tick();
    checks++; if (ins_v !== 1'b0) begin errors++; $display("FAIL lat_c3_v: got %b expected 0", ins_v); end
    checks++; if (ins !== 32'hDEADBEEF) begin errors++; $display("FAIL lat_hold: got %h expected %h", ins, 32'hDEADBEEF); end
  endtask

  task automatic test_byte_write;
    wr(16'h0014, 4'hF, 32'h11223344);
    wr(16'h0014, 4'b0101, 32'hAABBCCDD);
    dat_re = 1'b1;
    tick();
    dat_re = 1'b0;
    tick();
    checks++; if (dat_v !== 1'b1) begin errors++; $display("FAIL bw_v: got %b expected 1", dat_v); end
    checks++; if (dat_rd !== 32'h11BB33DD) begin errors++; $display("FAIL bw_data: got %h expected %h", dat_rd, 32'h11BB33DD); end
    dat_re = 1'b1;
    dat_we = 4'hF;
    dat_wd = 32'h0;
    tick();
    dat_we = '0;
    tick();
    dat_re = 1'b0;
    checks++; if (dat_rd !== 32'h11BB33DD || dat_v !== 1'b1) begin errors++; $display("FAIL rw_same_cycle: got %h v=%b expected %h v=1", dat_rd, dat_v, 32'h11BB33DD); end
    tick();
    checks++; if (dat_rd !== 32'h0 || dat_v !== 1'b1) begin errors++; $display("FAIL raw_next: got %h v=%b expected %h v=1", dat_rd, dat_v, 32'h0); end
    tick();
    checks++; if (dat_v !== 1'b0) begin errors++; $display("FAIL raw_v_drop: got %b expected 0", dat_v); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [4];
    vals[0] = 32'h0102_0304;
    vals[1] = 32'h5566_7788;
    vals[2] = 32'h99AA_BBCC;
    vals[3] = 32'hF00D_1234;
    for (int i = 0; i < 4; i++) wr(16'(i * 4), 4'hF, vals[i]);
    for (int c = 0; c < 6; c++) begin
      ins_e = (c < 4);
      ins_a = 16'(c * 4);
      tick();
      if (c >= 1 && c <= 4) begin
        checks++; if (ins_v !== 1'b1 || ins !== vals[c-1]) begin errors++; $display("FAIL b2b_%0d: got %h v=%b expected %h v=1", c, ins, ins_v, vals[c-1]); end
      end else begin
        checks++; if (ins_v !== 1'b0) begin errors++; $display("FAIL b2b_idle_%0d: got v=%b expected 0", c, ins_v); end
      end
    end
  endtask

  task automatic test_errors;
    dat_re = 1'b1;
    dat_a = 16'h0002;
    tick();
    dat_re = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mis_early_err: got %b expected 0", err); end
    tick();
    checks++; if (dat_v !== 1'b1 || dat_rd !== 32'h0 || err !== 1'b1) begin errors++; $display("FAIL mis_read: got %h v=%b err=%b expected 0 v=1 err=1", dat_rd, dat_v, err); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mis_err_pulse: got %b expected 0", err); end
    ins_e = 1'b1;
    ins_a = 16'hFFFC;
    tick();
    ins_e = 1'b0;
    tick();
    checks++; if (ins_v !== 1'b1 || ins !== 32'h0 || err !== 1'b1) begin errors++; $display("FAIL oor_read: got %h v=%b err=%b expected 0 v=1 err=1", ins, ins_v, err); end
    wr(16'h0016, 4'hF, 32'hFFFFFFFF);
    tick();
    checks++; if (err !== 1'b1 || dat_v !== 1'b0) begin errors++; $display("FAIL mis_write_err: got err=%b v=%b expected err=1 v=0", err, dat_v); end
    wr(16'h1014, 4'hF, 32'hFFFFFFFF);
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_write_err: got %b expected 1", err); end
    dat_re = 1'b1;
    dat_a = 16'h0014;
    tick();
    dat_re = 1'b0;
    tick();
    checks++; if (dat_v !== 1'b1 || dat_rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL array_unchanged: got %h v=%b err=%b expected 0 v=1 err=0", dat_rd, dat_v, err); end
  endtask

  task automatic test_collision;
    logic [31:0] exp_ins;
`ifdef SRAM_BANK_BYPASS_EN
    exp_ins = 32'hCAFEF00D;
`else
    exp_ins = 32'h0;
`endif
    wr(16'h001C, 4'hF, 32'h0);
    ins_e = 1'b1;
    ins_a = 16'h001C;
    dat_we = 4'hF;
    dat_a = 16'h001C;
    dat_wd = 32'hCAFEF00D;
    tick();
    ins_e = 1'b0;
    dat_we = '0;
    tick();
    checks++; if (ins_v !== 1'b1 || ins !== exp_ins) begin errors++; $display("FAIL collision_ins: got %h v=%b expected %h v=1", ins, ins_v, exp_ins); end
    dat_re = 1'b1;
    tick();
    dat_re = 1'b0;
    tick();
    checks++; if (dat_v !== 1'b1 || dat_rd !== 32'hCAFEF00D) begin errors++; $display("FAIL collision_dat: got %h v=%b expected %h v=1", dat_rd, dat_v, 32'hCAFEF00D); end
  endtask

  task automatic test_reset_midflight;
    logic bad;
    ins_e = 1'b1;
    ins_a = 16'h0040;
    tick();
    ins_e = 1'b0;
    tick();
    checks++; if (ins !== 32'hDEADBEEF) begin errors++; $display("FAIL mf_pre: got %h expected %h", ins, 32'hDEADBEEF); end
    ins_e = 1'b1;
    ins_a = 16'h0004;
    tick();
    ins_e = 1'b0;
    rstn = 1'b0;
    #1;
    checks++; if (ins_v !== 1'b0 || ins !== 32'h0) begin errors++; $display("FAIL mf_in_reset: got %h v=%b expected 0 v=0", ins, ins_v); end
    tick();
    rstn = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (ins_v !== 1'b0 || ins !== 32'h0 || err !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL mf_dropped: got ins=%h v=%b expected no valid and ins=0", ins, ins_v); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_byte_write();
    test_back_to_back();
    test_errors();
    test_collision();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
